// File: rtl/drum_spi_pkg.sv
// drum_spi_pkg: shared types, widths and command check for the drum SPI link.
package drum_spi_pkg;
  localparam int DRUM_CMD_W    = 8;
  localparam int DRUM_CODE_W   = 4;
  localparam int DRUM_CODE_MAX = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_ACK} drum_spi_mst_state_t;
  function automatic logic cmd_ok(input logic [DRUM_CMD_W-1:0] b);
    return (b[DRUM_CMD_W-1:DRUM_CODE_W] == '0) && (b[DRUM_CODE_W-1:0] <= DRUM_CODE_W'(DRUM_CODE_MAX));
  endfunction
endpackage

// File: rtl/drum_spi_sck_gen.sv
// drum_spi_sck_gen: CPOL=0 SCK generator, CLK_DIV clk cycles per half-period, 8 bits per run.
module drum_spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       stop_i,
  output logic       sck_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic [2:0] bit_cnt_o
);
  localparam int DW = $clog2(CLK_DIV);
  logic          active_q, sck_q, tick;
  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  assign tick      = active_q && (div_q == DW'(CLK_DIV - 1));
  assign rise_o    = tick && !sck_q;
  assign fall_o    = tick && sck_q;
  assign sck_o     = sck_q;
  assign bit_cnt_o = bit_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
    end else if (start_i || stop_i) begin
      active_q <= !stop_i;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
    end else if (active_q) begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) sck_q <= !sck_q;
      if (fall_o) bit_q <= bit_q + 3'd1;
      if (fall_o && bit_q == 3'd7) active_q <= 1'b0;
    end
  end
endmodule

// File: rtl/drum_spi_master.sv
// drum_spi_master: reads one drum command byte per DONE handshake and pulses the decoded code.
// Define DRUM_SPI_MASTER_TIMEOUT_EN to abandon an ACK the slave never answers.
module drum_spi_master
  import drum_spi_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   done,
  input  logic                   sdi,
  output logic                   sck,
  output logic                   sdo,
  output logic                   load,
  output logic                   rx_valid,
  output logic [DRUM_CODE_W-1:0] rx_code,
  output logic                   rx_error,
  output logic                   busy
);
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  drum_spi_mst_state_t   state_q, state_d;
  logic                  done_s1_q, done_s2_q;
  logic [SW-1:0]         setup_q, setup_d;
  logic [DRUM_CMD_W-1:0] shift_q;
  logic [DRUM_CODE_W-1:0] code_q;
  logic                  load_q, load_d, valid_q, valid_d, error_q, error_d;
  logic                  sck_start, sck_stop, sck_rise, sck_fall, sck_last, timeout;
  logic [2:0]            bit_cnt;

  drum_spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (sck_start),
    .stop_i   (sck_stop),
    .sck_o    (sck),
    .rise_o   (sck_rise),
    .fall_o   (sck_fall),
    .bit_cnt_o(bit_cnt)
  );

  assign sck_last = sck_fall && (bit_cnt == 3'(DRUM_CMD_W - 1));

`ifdef DRUM_SPI_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= (state_q == ST_ACK) ? to_q + 1'b1 : '0;
  end
  assign timeout = (to_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    setup_d   = '0;
    sck_start = 1'b0;
    sck_stop  = 1'b0;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = (enable && done_s2_q) ? ST_SETUP : ST_IDLE;
      ST_SETUP: begin
        setup_d = setup_q + 1'b1;
        if (!done_s2_q) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (setup_q == SW'(SETUP_CYCLES - 1)) begin
          state_d   = ST_SHIFT;
          sck_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!done_s2_q) begin
          state_d  = ST_IDLE;
          sck_stop = 1'b1;
          error_d  = 1'b1;
        end else if (sck_last) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!done_s2_q || timeout) begin
          state_d = ST_IDLE;
          valid_d = !done_s2_q && cmd_ok(shift_q);
          error_d = !valid_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // load rises the cycle after the last SCK fall and drops together with the result pulse
  assign load_d = (state_q == ST_ACK) && (state_d == ST_ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
      setup_q   <= '0;
      load_q    <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      done_s1_q <= done;
      done_s2_q <= done_s1_q;
      setup_q   <= setup_d;
      load_q    <= load_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      if (valid_d) code_q <= shift_q[DRUM_CODE_W-1:0];
      if (sck_rise) shift_q <= {shift_q[DRUM_CMD_W-2:0], sdi};
    end
  end

  assign sdo      = 1'b0;
  assign load     = load_q;
  assign rx_valid = valid_q;
  assign rx_error = error_q;
  assign rx_code  = code_q;
  assign busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_drum_spi_master.sv
// tb_drum_spi_master: directed and random frames against a byte-level slave/decoder model.
module tb_drum_spi_master;
  localparam int CD = 4;
  localparam int SC = 4;

  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0, done = 1'b0, sdi = 1'b0;
  logic sck, sdo, load, rx_valid, rx_error, busy;
  logic [3:0] rx_code;
  logic [7:0] tx;
  logic [3:0] exp_code = 4'd0;
  int checks = 0, errors = 0;
  int n, rise_cnt, first_rise, last_rise, last_fall, busy_n, load_n, idx, pn;
  logic psck;
  bit seen;

  always #5 clk = ~clk;

  drum_spi_master dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .done(done), .sdi(sdi),
    .sck(sck), .sdo(sdo), .load(load), .rx_valid(rx_valid),
    .rx_code(rx_code), .rx_error(rx_error), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk cycle seen from the slave side: edge tracking plus MSB-first data on sdi.
  task automatic step();
    @(negedge clk);
    n++;
    if (!psck && sck) begin
      rise_cnt++;
      if (rise_cnt == 1) first_rise = n;
      last_rise = n;
    end
    if (psck && !sck) begin
      idx++;
      last_fall = n;
    end
    if (busy && busy_n < 0) busy_n = n;
    if (load && load_n < 0) load_n = n;
    psck = sck;
    sdi  = (idx < 8) ? tx[3'(7 - idx)] : 1'b0;
  endtask

  task automatic arm(input logic [7:0] b);
    tx = b; idx = 0; n = 0; rise_cnt = 0;
    first_rise = -1; last_rise = -1; last_fall = -1; busy_n = -1; load_n = -1;
    psck = sck; sdi = b[7];
  endtask

  task automatic wait_pulse();
    pn = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rx_valid || rx_error) begin pn = k; break; end
    end
  endtask

  // off = clk cycles still needed for done to pass the synchronizer
  task automatic frame(input logic [7:0] b, input int off, input int ack_delay);
    bit ok;
    while (load_n < 0 && n < 400) step();
    chk("load_seen", load_n >= 0, 1);
    chk("busy_rise", busy_n, off + 1);
    chk("first_rise", first_rise, off + 1 + SC + CD);
    chk("rise_count", rise_cnt, 8);
    chk("rise_span", last_rise - first_rise, 7 * 2 * CD);
    chk("load_after_fall", load_n - last_fall, 1);
    repeat (ack_delay) step();
    chk("load_held", load, 1);
    done = 1'b0;
    wait_pulse();
    ok = int'(b) <= 7;
    if (ok) exp_code = b[3:0];
    chk("pulse_delay", pn, 3);
    chk("rx_valid", rx_valid, ok);
    chk("rx_error", rx_error, !ok);
    chk("load_fall", load, 0);
    chk("rx_code", rx_code, exp_code);
    step();
    chk("pulse_width", {rx_valid, rx_error}, 2'b00);
    chk("busy_idle", busy, 0);
  endtask

  task automatic std_frame(input logic [7:0] b, input int d);
    arm(b);
    done = 1'b1;
    frame(b, 2, d);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_sck", sck, 0); chk("rst_sdo", sdo, 0); chk("rst_load", load, 0);
    chk("rst_valid", rx_valid, 0); chk("rst_error", rx_error, 0);
    chk("rst_busy", busy, 0); chk("rst_code", rx_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    std_frame(8'h05, 1);
    std_frame(8'h17, 0);
    std_frame(8'h07, 2);
    std_frame(8'h08, 1);
    std_frame(8'h00, 3);
    std_frame(8'h70, 0);
    for (int i = 0; i < 6; i++)
      std_frame((i % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    std_frame(8'h06, 0);

    // enable low: done high must not start a frame
    enable = 1'b0;
    arm(8'h02);
    done = 1'b1;
    repeat (30) step();
    chk("disabled_no_sck", rise_cnt, 0);
    chk("disabled_busy", busy, 0);
    arm(8'h02);
    enable = 1'b1;
    frame(8'h02, 0, 1);
    repeat (3) @(negedge clk);

    // done drops after the 3rd SCK rise
    arm(8'h05);
    done = 1'b1;
    while (rise_cnt < 3 && n < 200) step();
    done = 1'b0;
    wait_pulse();
    chk("abort_delay", pn, 3);
    chk("abort_error", rx_error, 1);
    chk("abort_valid", rx_valid, 0);
    chk("abort_sck", sck, 0);
    chk("abort_busy", busy, 0);
    chk("abort_load_seen", load_n >= 0, 0);
    chk("abort_rises", rise_cnt, 3);
    chk("abort_code", rx_code, exp_code);
    repeat (3) @(negedge clk);

    // asynchronous reset during bit 4
    arm(8'h03);
    done = 1'b1;
    while (rise_cnt < 4 && n < 200) step();
    step();
    #2 rst_n = 1'b0;
    #1;
    exp_code = 4'd0;
    chk("mid_rst_sck", sck, 0); chk("mid_rst_load", load, 0);
    chk("mid_rst_valid", rx_valid, 0); chk("mid_rst_error", rx_error, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_code", rx_code, 0); chk("mid_rst_sdo", sdo, 0);
    @(negedge clk);
    arm(8'h03);
    rst_n = 1'b1;
    frame(8'h03, 2, 1);
    repeat (3) @(negedge clk);

    // slave never releases done while load is high
    arm(8'h04);
    done = 1'b1;
    while (load_n < 0 && n < 400) step();
    chk("hold_load_seen", load_n >= 0, 1);
`ifdef DRUM_SPI_MASTER_TIMEOUT_EN
    seen = 1'b0;
    for (int k = 0; k < 1200 && !seen; k++) begin
      step();
      seen = rx_error;
    end
    chk("timeout_error", rx_error, 1);
    chk("timeout_load", load, 0);
    chk("timeout_valid", rx_valid, 0);
    chk("timeout_code", rx_code, exp_code);
    enable = 1'b0;
    done = 1'b0;
    repeat (20) @(negedge clk);
`else
    seen = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      step();
      if (rx_valid || rx_error || !load) seen = 1'b1;
    end
    chk("ack_hold_load", load, 1);
    chk("ack_hold_quiet", seen, 0);
    done = 1'b0;
    wait_pulse();
    exp_code = 4'd4;
    chk("ack_release_delay", pn, 3);
    chk("ack_release_valid", rx_valid, 1);
    chk("ack_release_code", rx_code, exp_code);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/drum_spi_master.md
# drum_spi_master

FPGA-side SPI master that reads 1-byte drum commands from a `drum_spi_slave` over the SCK/SDO/LOAD/DONE link. It waits for DONE, clocks one byte in CPOL=0/CPHA=0, acknowledges with LOAD, and presents the decoded drum code as a one-cycle pulse. It serves as the hardware loopback partner for on-board testing and as the reader on any FPGA-to-FPGA drum link.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCK half-period (≥2).
- `SETUP_CYCLES`, 4: `clk` cycles between DONE being seen and the first SCK rise.
- `TIMEOUT_CYCLES`, 1024: ACK-wait limit, used only with the macro.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: allow new frames to start.
- `done` in 1: slave data-ready, asynchronous; synchronized internally with 2 flops.
- `sdi` in 1: MISO from the slave, asynchronous; sampled as described under Operation.
- `sck` out 1: SPI clock, idles low.
- `sdo` out 1: MOSI, constant 0.
- `load` out 1: acknowledge to the slave.
- `rx_valid` out 1: one-cycle pulse, received command valid.
- `rx_code` out 4: received drum code, held until the next `rx_valid`.
- `rx_error` out 1: one-cycle pulse on a bad frame.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE → SETUP → SHIFT → ACK → (IDLE).
- IDLE:
  - If `enable` and synced `done`=1, go to SETUP.
  - If `done` is already high out of reset, a frame starts.
- SETUP: wait `SETUP_CYCLES` with `sck` low, then go to SHIFT.
- SHIFT:
  - 8 bits, MSB first.
  - Each bit: `sck` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - `sdi` is registered on the `clk` edge that drives `sck` high.
  - After bit 0's high phase, drive `sck` low and go to ACK.
- ACK:
  - Assert `load`.
  - Hold it until synced `done`=0, then deassert `load` and go to IDLE.
  - In the same cycle, pulse `rx_valid` or `rx_error`.
- Byte check:
  - Byte[7:4]≠0 or byte[3:0]>7: `rx_error` pulses and `rx_code` is unchanged.
  - Otherwise: `rx_valid` pulses and `rx_code`=byte[3:0].
- Synced `done` falling during SETUP or SHIFT:
  - Abort: `sck` low, `rx_error` pulse, return to IDLE.
  - No `load` is issued.
- `enable` falling mid-frame: the current frame completes normally.
- Slave re-triggered before ACK: `done` stays high and the byte already latched is reported. The next frame starts as soon as `done` is seen high again in IDLE.

## Timing
- Reset values: `sck`=0, `sdo`=0, `load`=0, `rx_valid`=0, `rx_error`=0, `busy`=0, `rx_code`=0, state=IDLE.
- `busy` rises 1 cycle after synced `done` is seen in IDLE.
- Raw `done` rising to first SCK rise: 2 sync cycles + 1 + `SETUP_CYCLES` + `CLK_DIV`.
- SHIFT length: 16·`CLK_DIV` cycles. `load` rises the cycle after the last SCK fall.
- `rx_valid` pulses in the same cycle `load` falls: 1 cycle after synced `done`=0.
- Asynchronous reset mid-frame: all outputs return to their reset values immediately and `sck` drops without completing the bit.

## Configuration
- `DRUM_SPI_MASTER_TIMEOUT_EN` defined:
  - A counter runs in ACK.
  - If `done` has not fallen after `TIMEOUT_CYCLES`, `load` drops, `rx_error` pulses, and the state returns to IDLE.
  - The received byte is discarded.
- `DRUM_SPI_MASTER_TIMEOUT_EN` undefined: ACK waits indefinitely and no counter is built.

## Structure
- Package `drum_spi_pkg` contains:
  - state enum `drum_spi_mst_state_t`;
  - `DRUM_CMD_W`=8;
  - `DRUM_CODE_W`=4;
  - `DRUM_CODE_MAX`=7.
- Sub-module `drum_spi_sck_gen`:
  - Half-period counter.
  - Produces `sck`, a rise strobe, a fall strobe and a bit counter.
  - Started and stopped by the master FSM.
- The 2-flop synchronizers are inline in the top module.

## Test plan
- Slave model returns 0x05, `CLK_DIV`=4 → exactly 8 SCK rises with 8-cycle period; `load` high after the 8th fall; `rx_valid` pulse with `rx_code`=5, the cycle after `done` falls.
- Byte 0x17 → `rx_error` pulse, no `rx_valid`, `rx_code` keeps its previous value.
- `done` dropped after the 3rd SCK rise → `sck` low next cycle, `rx_error` pulse, `load` never asserted, `busy`=0.
- `enable`=0 with `done` high → no SCK activity. `enable`=1 → frame starts 1 cycle after the synced `done` is seen.
- `rst_n` pulsed low during bit 4 → all outputs zero immediately. After release with `done` still high, a fresh frame reads the full byte correctly.
- With `DRUM_SPI_MASTER_TIMEOUT_EN`, `done` stuck high in ACK → after 1024 cycles `load` drops and `rx_error` pulses. Without the macro, `load` stays high indefinitely.
